// File: rtl/keystream_shifter.sv
// Key word generator: loads a seed, then emits KEY_SIZE words from the top of a
// state register that advances STEP positions (rotl/rotr/LFSR/zero-fill) per accepted word.
module keystream_step #(
    parameter int                  MSG_SIZE  = 32,
    parameter logic [MSG_SIZE-1:0] LFSR_TAPS = 32'h80200003
) (
    input  logic [1:0]          mode,
    input  logic [MSG_SIZE-1:0] s,
    output logic [MSG_SIZE-1:0] n
);
    always_comb begin
        n = s;
        case (mode)
            2'b00:   n = {s[MSG_SIZE-2:0], s[MSG_SIZE-1]};
            2'b01:   n = {s[0], s[MSG_SIZE-1:1]};
            2'b10:   n = {s[MSG_SIZE-2:0], ^(s & LFSR_TAPS)};
            default: n = {s[MSG_SIZE-2:0], 1'b0};
        endcase
    end
endmodule

module keystream_shifter #(
    parameter int                  MSG_SIZE  = 32,
    parameter int                  KEY_SIZE  = 8,
    parameter int                  STEP      = 1,
    parameter logic [MSG_SIZE-1:0] LFSR_TAPS = 32'h80200003,
    parameter int                  MAX_WORDS = 16,
    localparam int                 CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [MSG_SIZE-1:0] initial_msg,
    input  logic [1:0]          mode,
    input  logic                out_ready,
    output logic [KEY_SIZE-1:0] out,
    output logic                out_valid,
    output logic [CNT_W-1:0]    word_count,
    output logic                done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [MSG_SIZE-1:0] state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                fire;

    // STEP single-bit steps chained combinationally so a whole advance lands in one cycle
    logic [STEP:0][MSG_SIZE-1:0] chain;
    assign chain[0] = state_q;

    for (genvar i = 0; i < STEP; i++) begin : g_step
        keystream_step #(
            .MSG_SIZE (MSG_SIZE),
            .LFSR_TAPS(LFSR_TAPS)
        ) u_step (
            .mode(mode_q),
            .s   (chain[i]),
            .n   (chain[i+1])
        );
    end

    assign out        = state_q[MSG_SIZE-1 -: KEY_SIZE];
    assign out_valid  = (fsm_q == S_RUN);
    assign done       = (fsm_q == S_DONE);
    assign word_count = count_q;
    assign fire       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            mode_q  <= '0;
            count_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        if (load) begin
            // an all-zero LFSR seed would lock up, so it is replaced by 1
            fsm_d   = S_RUN;
            mode_d  = mode;
            count_d = '0;
            state_d = (mode == 2'b10 && initial_msg == '0) ?
                      {{(MSG_SIZE-1){1'b0}}, 1'b1} : initial_msg;
        end else if (fire) begin
            state_d = chain[STEP];
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(MAX_WORDS - 1))
                fsm_d = S_DONE;
        end
    end
endmodule

// File: tb/tb_keystream_shifter.sv
// Scoreboard bench: stimulus queues expected words/status, a negedge monitor pops and compares.
module tb_keystream_shifter;
    typedef struct packed {
        logic [31:0] o;
        logic        v;
        logic [7:0]  c;
        logic        d;
    } st_t;

    logic        clk, rst_n;
    logic        load, ready, load4, ready4;
    logic [31:0] msg, msg4;
    logic [1:0]  mode, mode4;
    logic [7:0]  ks_out;
    logic        ks_vld, ks_done;
    logic [2:0]  ks_cnt;
    logic [31:0] k4_out;
    logic        k4_vld, k4_done;
    logic [4:0]  k4_cnt;
    logic        chk, chk4;
    int          nchk, npass;
    st_t         wq[$], sq[$], sq4[$];

    keystream_shifter #(.MSG_SIZE(32), .KEY_SIZE(8), .STEP(1), .MAX_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .initial_msg(msg), .mode(mode),
        .out_ready(ready), .out(ks_out), .out_valid(ks_vld), .word_count(ks_cnt), .done(ks_done)
    );

    // full-width key word and STEP 4 so every state bit is visible
    keystream_shifter #(.MSG_SIZE(32), .KEY_SIZE(32), .STEP(4), .MAX_WORDS(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .initial_msg(msg4), .mode(mode4),
        .out_ready(ready4), .out(k4_out), .out_valid(k4_vld), .word_count(k4_cnt), .done(k4_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input st_t act, input st_t exp);
        nchk++;
        if (act !== exp)
            $display("FAIL %s: got out=%h vld=%b cnt=%0d done=%b, want out=%h vld=%b cnt=%0d done=%b",
                     nm, act.o, act.v, act.c, act.d, exp.o, exp.v, exp.c, exp.d);
        else
            npass++;
    endtask

    always @(negedge clk) begin
        if (ks_vld && ready) begin
            if (wq.size() == 0) begin
                nchk++;
                $display("FAIL word: unexpected handshake out=%h cnt=%0d", ks_out, ks_cnt);
            end else
                check("word", st_t'({24'h0, ks_out, ks_vld, 5'h0, ks_cnt, ks_done}), wq.pop_front());
        end
        if (chk && sq.size() > 0)
            check("status", st_t'({24'h0, ks_out, ks_vld, 5'h0, ks_cnt, ks_done}), sq.pop_front());
        if (chk4 && sq4.size() > 0)
            check("status4", st_t'({k4_out, k4_vld, 3'h0, k4_cnt, k4_done}), sq4.pop_front());
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wexp(input logic [7:0] o, input logic [7:0] c);
        wq.push_back('{o: {24'h0, o}, v: 1'b1, c: c, d: 1'b0});
    endtask

    task automatic stat(input logic [7:0] o, input logic v, input logic [7:0] c, input logic d);
        sq.push_back('{o: {24'h0, o}, v: v, c: c, d: d});
        chk = 1'b1;
        cyc();
        chk = 1'b0;
    endtask

    task automatic stat4(input logic [31:0] o, input logic v, input logic [7:0] c, input logic d);
        sq4.push_back('{o: o, v: v, c: c, d: d});
        chk4 = 1'b1;
        cyc();
        chk4 = 1'b0;
    endtask

    task automatic load_run(input logic [31:0] seed, input logic [1:0] md);
        load = 1'b1; msg = seed; mode = md;
        cyc();
        load = 1'b0;
    endtask

    task automatic run4(input logic [31:0] seed, input logic [1:0] md, input logic [31:0] loaded,
                        input int n, input logic [31:0] fin);
        load4 = 1'b1; msg4 = seed; mode4 = md;
        cyc();
        load4 = 1'b0;
        stat4(loaded, 1'b1, 8'd0, 1'b0);
        ready4 = 1'b1;
        repeat (n) cyc();
        ready4 = 1'b0;
        stat4(fin, 1'b1, 8'(n), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nchk = 0; npass = 0; chk = 0; chk4 = 0;
        rst_n = 0; load = 0; ready = 0; msg = '0; mode = '0;
        load4 = 0; ready4 = 0; msg4 = '0; mode4 = '0;
        cyc(); cyc();
        stat(8'h00, 1'b0, 8'd0, 1'b0);
        stat4(32'h0, 1'b0, 8'd0, 1'b0);
        rst_n = 1;

        // rotl; mode change after load ignored; backpressure holds the word
        load_run(32'hABCDEF01, 2'b00);
        mode = 2'b01;
        stat(8'hAB, 1'b1, 8'd0, 1'b0);
        repeat (5) cyc();
        stat(8'hAB, 1'b1, 8'd0, 1'b0);
        ready = 1; wexp(8'hAB, 8'd0); cyc(); ready = 0;
        stat(8'h57, 1'b1, 8'd1, 1'b0);

        // LFSR zero-seed lock-up
        load_run(32'h0, 2'b10);
        stat(8'h00, 1'b1, 8'd0, 1'b0);
        ready = 1; wexp(8'h00, 8'd0); cyc(); ready = 0;
        stat(8'h00, 1'b1, 8'd1, 1'b0);

        // budget of 4 words, DONE holds, reload in rotr
        load_run(32'hABCDEF01, 2'b00);
        wexp(8'hAB, 8'd0); wexp(8'h57, 8'd1); wexp(8'hAF, 8'd2); wexp(8'h5E, 8'd3);
        ready = 1;
        repeat (4) cyc();
        stat(8'hBC, 1'b0, 8'd4, 1'b1);
        stat(8'hBC, 1'b0, 8'd4, 1'b1);
        ready = 0;
        load_run(32'hABCDEF01, 2'b01);
        stat(8'hAB, 1'b1, 8'd0, 1'b0);
        ready = 1; wexp(8'hAB, 8'd0); cyc(); ready = 0;
        stat(8'hD5, 1'b1, 8'd1, 1'b0);

        // reset beats load mid-stream; IDLE ignores ready
        rst_n = 0; load = 1; msg = 32'hABCDEF01; ready = 1; wexp(8'hD5, 8'd1);
        cyc();
        rst_n = 1; load = 0;
        stat(8'h00, 1'b0, 8'd0, 1'b0);
        ready = 0;

        // load wins over a same-cycle handshake
        load_run(32'hABCDEF01, 2'b00);
        load = 1; msg = 32'h12345678; mode = 2'b00; ready = 1; wexp(8'hAB, 8'd0);
        cyc();
        load = 0; ready = 0;
        stat(8'h12, 1'b1, 8'd0, 1'b0);

        // STEP 4, full-width view
        run4(32'hABCDEF01, 2'b01, 32'hABCDEF01, 1, 32'h1ABCDEF0);
        run4(32'hABCDEF01, 2'b00, 32'hABCDEF01, 2, 32'hCDEF01AB);
        run4(32'hABCDEF01, 2'b11, 32'hABCDEF01, 1, 32'hBCDEF010);
        run4(32'h00000000, 2'b10, 32'h00000001, 1, 32'h0000001B);
        run4(32'h00200000, 2'b10, 32'h00200000, 1, 32'h0200000D);
        run4(32'h80000000, 2'b10, 32'h80000000, 1, 32'h0000000D);
        run4(32'h00000000, 2'b00, 32'h00000000, 1, 32'h00000000);

        cyc();
        nchk++;
        if (wq.size() != 0 || sq.size() != 0 || sq4.size() != 0)
            $display("FAIL drain: leftover words=%0d status=%0d status4=%0d, want 0",
                     wq.size(), sq.size(), sq4.size());
        else
            npass++;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
